// File: rtl/hilo_mdu.sv
// hilo_mdu: HI/LO multiply/divide unit with iterative shift-add multiply and restoring divide.
// Define FAST_MUL_EN to replace the 32-cycle multiply with a single-cycle 64-bit multiplier.
module hilo_mdu #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic [2:0]    op,
  input  logic [DW-1:0] src_a,
  input  logic [DW-1:0] src_b,
  input  logic          flush,
  output logic          stall,
  output logic          hi_we,
  output logic [DW-1:0] hi_wdata,
  output logic          lo_we,
  output logic [DW-1:0] lo_wdata
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t          state_q, state_d;
  logic [4:0]      count_q, count_d;
  logic [DW-1:0]   m_q, m_d;
  logic [2*DW-1:0] p_q, p_d;
  logic            neg_q, neg_d, rneg_q, rneg_d;
  logic            hi_we_q, hi_we_d, lo_we_q, lo_we_d;
  logic [DW-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic            acc, sgn, last, ge;
  logic [DW-1:0]   abs_a, abs_b, quo, rem;
  logic [DW:0]     r;
  logic [2*DW-1:0] mul_next, div_next, res;
`ifndef FAST_MUL_EN
  logic [DW:0]     sum;
`endif
  // p_q holds {hi, multiplier} while multiplying and {remainder, dividend/quotient} while dividing
  always_comb begin
    acc = resetn && start && !flush && state_q == IDLE;
    sgn = op == 3'd1 || op == 3'd3;
    abs_a = sgn && src_a[DW-1] ? -src_a : src_a;
    abs_b = sgn && src_b[DW-1] ? -src_b : src_b;
`ifdef FAST_MUL_EN
    mul_next = {{DW{1'b0}}, m_q} * {{DW{1'b0}}, p_q[DW-1:0]};
    last = state_q == MUL || count_q == 5'd31;
`else
    sum = {1'b0, p_q[2*DW-1:DW]} + (p_q[0] ? {1'b0, m_q} : '0);
    mul_next = {sum, p_q[DW-1:1]};
    last = count_q == 5'd31;
`endif
    r = p_q[2*DW-1:DW-1];
    ge = r >= {1'b0, m_q};
    div_next = {ge ? r[DW-1:0] - m_q : r[DW-1:0], p_q[DW-2:0], ge};
    quo = neg_q ? -div_next[DW-1:0] : div_next[DW-1:0];
    rem = rneg_q ? -div_next[2*DW-1:DW] : div_next[2*DW-1:DW];
    res = state_q == MUL ? (neg_q ? -mul_next : mul_next) : {rem, quo};
    stall = (acc && op >= 3'd1 && op <= 3'd4) || state_q == MUL || state_q == DIV;
    state_d = state_q;
    count_d = count_q;
    m_d = m_q;
    p_d = p_q;
    neg_d = neg_q;
    rneg_d = rneg_q;
    hi_we_d = 1'b0;
    lo_we_d = 1'b0;
    hi_d = hi_q;
    lo_d = lo_q;
    if (acc) begin
      if (op >= 3'd1 && op <= 3'd4) begin
        state_d = op <= 3'd2 ? MUL : DIV;
        m_d = op <= 3'd2 ? abs_a : abs_b;
        p_d = {{DW{1'b0}}, op <= 3'd2 ? abs_b : abs_a};
        count_d = 5'd0;
        neg_d = sgn && (src_a[DW-1] ^ src_b[DW-1]);
        rneg_d = sgn && src_a[DW-1];
      end
      hi_we_d = op == 3'd5;
      lo_we_d = op == 3'd6;
      hi_d = op == 3'd5 ? src_a : hi_q;
      lo_d = op == 3'd6 ? src_a : lo_q;
    end else if (state_q == MUL || state_q == DIV) begin
      if (flush) state_d = IDLE;
      else begin
        count_d = count_q + 5'd1;
        p_d = state_q == MUL ? mul_next : div_next;
        if (last) begin
          state_d = DONE;
          hi_we_d = 1'b1;
          lo_we_d = 1'b1;
          hi_d = res[2*DW-1:DW];
          lo_d = res[DW-1:0];
        end
      end
    end else if (state_q == DONE) state_d = IDLE;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      count_q <= '0;
      m_q <= '0;
      p_q <= '0;
      neg_q <= 1'b0;
      rneg_q <= 1'b0;
      hi_we_q <= 1'b0;
      lo_we_q <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      m_q <= m_d;
      p_q <= p_d;
      neg_q <= neg_d;
      rneg_q <= rneg_d;
      hi_we_q <= hi_we_d;
      lo_we_q <= lo_we_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end
  assign hi_we = hi_we_q;
  assign lo_we = lo_we_q;
  assign hi_wdata = hi_q;
  assign lo_wdata = lo_q;
endmodule

// File: tb/tb_hilo_mdu.sv
// tb_hilo_mdu: random and directed stimulus for hilo_mdu checked every cycle against a
// transaction-level model (busy countdown plus arithmetic result), plus literal result pins.
module tb_hilo_mdu;
`ifdef FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 32;
`endif
  logic        clk = 0, resetn = 1, start = 0, flush = 0;
  logic [2:0]  op = 0;
  logic [31:0] src_a = 0, src_b = 0;
  logic        stall, hi_we, lo_we;
  logic [31:0] hi_wdata, lo_wdata;
  int tests = 0, fails = 0;
  int          m_busy = 0;
  logic        m_done = 0, e_hi_we = 0, e_lo_we = 0;
  logic [63:0] m_res = 0;
  logic [31:0] e_hi = 0, e_lo = 0;

  hilo_mdu dut (
    .clk(clk), .resetn(resetn), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .stall(stall), .hi_we(hi_we), .hi_wdata(hi_wdata), .lo_we(lo_we),
    .lo_wdata(lo_wdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (o == 3'd1) return sa * sb;
    if (o == 3'd2) return {32'd0, a} * {32'd0, b};
    if (o == 3'd4) return b == 0 ? {a, 32'hFFFFFFFF} : {a % b, a / b};
    if (b == 0) return {a, a[31] ? 32'd1 : 32'hFFFFFFFF};
    return {32'(sa % sb), 32'(sa / sb)};
  endfunction

  function automatic logic [31:0] rv();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'($urandom_range(0, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_busy <= 0; m_done <= 0; m_res <= 0;
      e_hi_we <= 0; e_lo_we <= 0; e_hi <= 0; e_lo <= 0;
    end else begin
      e_hi_we <= 0;
      e_lo_we <= 0;
      if (m_busy == 0 && !m_done) begin
        if (start && !flush) begin
          if (op >= 1 && op <= 4) begin
            m_busy <= op <= 2 ? MUL_LAT : 32;
            m_res <= ref_res(op, src_a, src_b);
          end else if (op == 5) begin
            e_hi_we <= 1; e_hi <= src_a;
          end else if (op == 6) begin
            e_lo_we <= 1; e_lo <= src_a;
          end
        end
      end else if (m_done) m_done <= 0;
      else if (flush) m_busy <= 0;
      else if (m_busy == 1) begin
        m_busy <= 0; m_done <= 1; e_hi_we <= 1; e_lo_we <= 1;
        e_hi <= m_res[63:32]; e_lo <= m_res[31:0];
      end else m_busy <= m_busy - 1;
    end
  end

  initial forever begin
    @(negedge clk);
    check("stall", stall, resetn && (m_busy != 0 || (!m_done && start && !flush && op >= 1 && op <= 4)));
    check("hi_we", hi_we, e_hi_we);
    check("lo_we", lo_we, e_lo_we);
    check("hi_wdata", hi_wdata, e_hi);
    check("lo_wdata", lo_wdata, e_lo);
  end

  task automatic go(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    start = 1; op = o; src_a = a; src_b = b;
    #1 check("accept stall", stall, 1);
    @(posedge clk); #1;
    start = 0; src_a = $urandom; src_b = $urandom;
  endtask

  task automatic run(input string name, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] eh, input logic [31:0] el);
    int c;
    go(o, a, b);
    c = 1;
    while (!(hi_we && lo_we) && c < 40) begin
      @(posedge clk); #1;
      c++;
    end
    check({name, " latency"}, c, o <= 2 ? MUL_LAT + 1 : 33);
    check({name, " hi"}, hi_wdata, eh);
    check({name, " lo"}, lo_wdata, el);
    check({name, " done stall"}, stall, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s;
    #2 resetn = 0;
    start = 1; op = 1;
    @(posedge clk); #1;
    check("reset stall", stall, 0);
    check("reset hi_we", hi_we, 0);
    check("reset lo_wdata", lo_wdata, 0);
    start = 0;
    @(posedge clk); #1 resetn = 1;
    run("MULTU max", 2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run("MULT -3*5", 1, -32'd3, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
    run("MULT min*min", 1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0);
    run("MULTU 6*7", 2, 32'd6, 32'd7, 32'd0, 32'd42);
    run("DIV -7/2", 3, -32'd7, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run("DIVU 100/0", 4, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF);
    run("DIV -5/0", 3, -32'd5, 32'd0, 32'hFFFFFFFB, 32'd1);
    run("DIV min/-1", 3, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);
    run("DIVU 1000/3", 4, 32'd1000, 32'd3, 32'd1, 32'd333);
    go(3, 32'd1000, 32'd3);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1;
    @(posedge clk); #1 flush = 0;
    check("flush stall low", stall, 0);
    @(posedge clk); #1;
    start = 1; op = 5; src_a = 32'h1234;
    @(posedge clk); #1 start = 0;
    check("MTHI hi_we", hi_we, 1);
    check("MTHI hi_wdata", hi_wdata, 32'h1234);
    check("MTHI lo_we", lo_we, 0);
    s = 0;
    repeat (40) begin @(posedge clk); #1; s += int'(hi_we) + int'(lo_we); end
    check("flush no strobe", s, 0);
    @(posedge clk); #1;
    start = 1; op = 6; src_a = 32'hA;
    @(posedge clk); #1 op = 5; src_a = 32'hB;
    check("b2b lo_we", lo_we, 1);
    check("b2b lo_wdata", lo_wdata, 32'hA);
    @(posedge clk); #1 start = 0;
    check("b2b hi_we", hi_we, 1);
    check("b2b hi_wdata", hi_wdata, 32'hB);
    check("b2b lo_we off", lo_we, 0);
    go(1, 32'd7, 32'd9);
    repeat (4) begin @(posedge clk); #1; end
    resetn = 0;
    #1;
    check("midop reset hi_wdata", hi_wdata, 0);
    check("midop reset lo_wdata", lo_wdata, 0);
    check("midop reset stall", stall, 0);
    @(posedge clk); #1 resetn = 1;
    s = 0;
    repeat (40) begin @(posedge clk); #1; s += int'(hi_we) + int'(lo_we); end
    check("midop reset no strobe", s, 0);
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      start = $urandom_range(0, 3) != 0;
      op = 3'($urandom_range(0, 7));
      flush = $urandom_range(0, 99) == 0;
      src_a = rv();
      src_b = rv();
    end
    start = 0; flush = 0;
    repeat (40) @(posedge clk);
    @(negedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
